// File: rtl/mb_rx_frame_ctrl_pkg.sv
// Shared types and constants for the MainBand receive framing controller.
package mb_rx_pkg;

  // Frame tracking states; DROP_* walk the same pattern without capturing.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HI       = 3'd1,
    LO0      = 3'd2,
    LO1      = 3'd3,
    DROP_HI  = 3'd4,
    DROP_LO0 = 3'd5,
    DROP_LO1 = 3'd6
  } frame_state_e;

  localparam int BEATS_PER_FRAG = 4;
  // Expected lane-valid level indexed by beat number (beats 0,1 high; 2,3 low).
  localparam logic [BEATS_PER_FRAG-1:0] VALID_PATTERN = 4'b0011;

  localparam int FRAG_BYTES = 16;
  localparam int FLIT_BYTES = 64;
  localparam int FRAGS_PER_FLIT_DFLT = FLIT_BYTES / FRAG_BYTES;

  // Valid level the link must present on a given beat of a fragment.
  function automatic logic beat_valid(input logic [1:0] beat);
    return VALID_PATTERN[beat];
  endfunction

  // Beat position within the fragment that a state consumes.
  function automatic logic [1:0] state_beat(input frame_state_e st);
    logic [1:0] beat;
    case (st)
      IDLE:              beat = 2'd0;
      HI, DROP_HI:       beat = 2'd1;
      LO0, DROP_LO0:     beat = 2'd2;
      LO1, DROP_LO1:     beat = 2'd3;
      default:           beat = 2'd0;
    endcase
    return beat;
  endfunction

endpackage

// File: rtl/mb_rx_frame_ctrl_if.sv
// Lane-side inputs and datapath/status outputs of the receive framing controller.
interface mb_rx_frame_ctrl_if #(
  parameter int FLIT_BUFFERS = 2,
  parameter int ERR_CNT_W    = 8
);
  localparam int SLOT_W = $clog2(FLIT_BUFFERS);

  logic                 rx_enable_i;
  logic                 valid_iPin;
  logic                 buf_release_i;
  logic                 sample_en_o;
  logic [SLOT_W-1:0]    wr_slot_o;
  logic [1:0]           wr_frag_o;
  logic [1:0]           wr_beat_o;
  logic [SLOT_W-1:0]    rd_slot_o;
  logic                 flit_ready_o;
  logic                 flit_done_o;
  logic                 full_o;
  logic                 overflow_o;
  logic                 frame_err_o;
  logic [ERR_CNT_W-1:0] err_cnt_o;
  logic                 underflow_o;

  modport master (
    output rx_enable_i, valid_iPin, buf_release_i,
    input  sample_en_o, wr_slot_o, wr_frag_o, wr_beat_o, rd_slot_o,
           flit_ready_o, flit_done_o, full_o, overflow_o, frame_err_o,
           err_cnt_o, underflow_o
  );

  modport slave (
    input  rx_enable_i, valid_iPin, buf_release_i,
    output sample_en_o, wr_slot_o, wr_frag_o, wr_beat_o, rd_slot_o,
           flit_ready_o, flit_done_o, full_o, overflow_o, frame_err_o,
           err_cnt_o, underflow_o
  );
endinterface

// File: rtl/mb_rx_frame_ctrl_slot_tracker.sv
// Flit-slot ring bookkeeping: write/read pointers, occupancy, full/ready, underflow.
module mb_rx_slot_tracker #(
  parameter int FLIT_BUFFERS = 2
) (
  input  logic                            periph_clkPins_i,
  input  logic                            reset,
  input  logic                            commit,
  input  logic                            rel,
  output logic [$clog2(FLIT_BUFFERS)-1:0] wr_slot,
  output logic [$clog2(FLIT_BUFFERS)-1:0] rd_slot,
  output logic                            ready,
  output logic                            full,
  output logic                            underflow
);
  localparam int SLOT_W = $clog2(FLIT_BUFFERS);
  localparam int OCC_W  = SLOT_W + 1;

  logic [SLOT_W-1:0] wr_slot_r;
  logic [SLOT_W-1:0] rd_slot_r;
  logic [OCC_W-1:0]  occ_r;
  logic              underflow_r;
  logic              rel_ok_s;

  // A release only counts when something is actually held.
  assign rel_ok_s = rel && (occ_r != OCC_W'(0));

  // Pointer advance and occupancy update; commit+release together leaves occupancy alone.
  always_ff @(posedge periph_clkPins_i) begin
    if (reset) begin
      wr_slot_r   <= '0;
      rd_slot_r   <= '0;
      occ_r       <= '0;
      underflow_r <= 1'b0;
    end else begin
      if (commit) begin
        wr_slot_r <= wr_slot_r + SLOT_W'(1);
      end
      if (rel_ok_s) begin
        rd_slot_r <= rd_slot_r + SLOT_W'(1);
      end
      if (rel && (occ_r == OCC_W'(0))) begin
        underflow_r <= 1'b1;
      end
      case ({commit, rel_ok_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign wr_slot   = wr_slot_r;
  assign rd_slot   = rd_slot_r;
  assign ready     = (occ_r != OCC_W'(0));
  assign full      = (occ_r == OCC_W'(FLIT_BUFFERS));
  assign underflow = underflow_r;
endmodule

// File: rtl/mb_rx_frame_ctrl.sv
// MainBand receive framing controller: tracks the 1100 valid pattern per fragment,
// emits per-beat capture strobes/indices and commits 4-fragment flits into slots.
module mb_rx_frame_ctrl
  import mb_rx_pkg::*;
#(
  parameter int FLIT_BUFFERS   = 2,
  parameter int FRAGS_PER_FLIT = FRAGS_PER_FLIT_DFLT,
  parameter int ERR_CNT_W      = 8
) (
  input logic               periph_clkPins_i,
  input logic               reset,
  mb_rx_frame_ctrl_if.slave rx
);
  localparam logic [1:0]           FRAG_LAST = 2'(FRAGS_PER_FLIT - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = {ERR_CNT_W{1'b1}};

  frame_state_e         state_r, state_s;
  logic [1:0]           frag_r, frag_s;
  logic [1:0]           drop_frag_r, drop_frag_s;
  logic [1:0]           beat_s;
  logic                 pat_ok_s;
  logic                 sample_s, commit_s, err_s, ovf_set_s, full_s;
  logic                 flit_done_r, frame_err_r, overflow_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  assign beat_s   = state_beat(state_r);
  assign pat_ok_s = (rx.valid_iPin == beat_valid(beat_s));

  // Next-state, capture strobe, commit and error decode for the current beat.
  always_comb begin
    state_s     = state_r;
    frag_s      = frag_r;
    drop_frag_s = drop_frag_r;
    sample_s    = 1'b0;
    commit_s    = 1'b0;
    err_s       = 1'b0;
    ovf_set_s   = 1'b0;
    if (!rx.rx_enable_i) begin
      // Link down: abandon any partial flit silently.
      state_s     = IDLE;
      frag_s      = 2'd0;
      drop_frag_s = 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!rx.valid_iPin) begin
            state_s = IDLE;
          end else if (drop_frag_r != 2'd0) begin
            state_s = DROP_HI;
          end else if ((frag_r != 2'd0) || !full_s) begin
            // Admission is decided once, at beat 0 of fragment 0.
            sample_s = 1'b1;
            state_s  = HI;
          end else begin
            ovf_set_s = 1'b1;
            state_s   = DROP_HI;
          end
        end
        HI, LO0, LO1, DROP_HI, DROP_LO0, DROP_LO1: begin
          if (!pat_ok_s) begin
            err_s       = 1'b1;
            state_s     = IDLE;
            frag_s      = 2'd0;
            drop_frag_s = 2'd0;
          end else begin
            sample_s = (state_r == HI) || (state_r == LO0) || (state_r == LO1);
            case (state_r)
              HI:       state_s = LO0;
              LO0:      state_s = LO1;
              DROP_HI:  state_s = DROP_LO0;
              DROP_LO0: state_s = DROP_LO1;
              LO1: begin
                state_s = IDLE;
                if (frag_r == FRAG_LAST) begin
                  frag_s   = 2'd0;
                  commit_s = 1'b1;
                end else begin
                  frag_s = frag_r + 2'd1;
                end
              end
              DROP_LO1: begin
                state_s = IDLE;
                if (drop_frag_r == FRAG_LAST) begin
                  drop_frag_s = 2'd0;
                end else begin
                  drop_frag_s = drop_frag_r + 2'd1;
                end
              end
              default: state_s = IDLE;
            endcase
          end
        end
        default: begin
          state_s     = IDLE;
          frag_s      = 2'd0;
          drop_frag_s = 2'd0;
        end
      endcase
    end
  end

  // State, fragment counters, status pulses, sticky overflow and saturating error count.
  always_ff @(posedge periph_clkPins_i) begin
    if (reset) begin
      state_r     <= IDLE;
      frag_r      <= 2'd0;
      drop_frag_r <= 2'd0;
      flit_done_r <= 1'b0;
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
      err_cnt_r   <= '0;
    end else begin
      state_r     <= state_s;
      frag_r      <= frag_s;
      drop_frag_r <= drop_frag_s;
      flit_done_r <= commit_s;
      frame_err_r <= err_s;
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end
      if (err_s && (err_cnt_r != ERR_MAX)) begin
        err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
      end
    end
  end

  mb_rx_slot_tracker #(
    .FLIT_BUFFERS(FLIT_BUFFERS)
  ) u_slots (
    .periph_clkPins_i(periph_clkPins_i),
    .reset           (reset),
    .commit          (commit_s),
    .rel             (rx.buf_release_i),
    .wr_slot         (rx.wr_slot_o),
    .rd_slot         (rx.rd_slot_o),
    .ready           (rx.flit_ready_o),
    .full            (full_s),
    .underflow       (rx.underflow_o)
  );

  assign rx.sample_en_o = sample_s;
  assign rx.wr_beat_o   = beat_s;
  assign rx.wr_frag_o   = frag_r;
  assign rx.full_o      = full_s;
  assign rx.flit_done_o = flit_done_r;
  assign rx.frame_err_o = frame_err_r;
  assign rx.overflow_o  = overflow_r;
  assign rx.err_cnt_o   = err_cnt_r;
endmodule

// File: tb/tb_mb_rx_frame_ctrl.sv
// Directed + randomized bench for mb_rx_frame_ctrl against a beat-level reference model.
module tb_mb_rx_frame_ctrl;
  localparam int NB      = 2;
  localparam int NF      = 4;
  localparam int EW      = 8;
  localparam int ERR_SAT = 255;

  logic periph_clkPins_i = 1'b0;
  logic reset;

  mb_rx_frame_ctrl_if #(.FLIT_BUFFERS(NB), .ERR_CNT_W(EW)) bus ();

  mb_rx_frame_ctrl #(
    .FLIT_BUFFERS  (NB),
    .FRAGS_PER_FLIT(NF),
    .ERR_CNT_W     (EW)
  ) dut (
    .periph_clkPins_i(periph_clkPins_i),
    .reset           (reset),
    .rx              (bus)
  );

  always #5 periph_clkPins_i = ~periph_clkPins_i;

  int checks = 0;
  int errors = 0;
  int samples_seen = 0;
  int ph = 0;

  // Reference model: position within the fragment, fragment count, drop state, ring state.
  int pat [4] = '{1, 1, 0, 0};
  int m_beat, m_frag, m_dropn, m_wr, m_rd, m_occ, m_err;
  bit m_drop, m_ovf, m_udf, m_done, m_ferr;

  function automatic void model_reset();
    m_beat = 0; m_frag = 0; m_dropn = 0; m_wr = 0; m_rd = 0; m_occ = 0; m_err = 0;
    m_drop = 0; m_ovf = 0; m_udf = 0; m_done = 0; m_ferr = 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One beat: drive inputs, check registered state, predict this beat, advance one clock.
  task automatic step(input bit rst, input bit en, input bit v, input bit rel);
    bit exp_samp;
    int exp_beat;
    bit rel_ok;
    bit commit;
    reset = rst;
    bus.rx_enable_i   = en;
    bus.valid_iPin    = v;
    bus.buf_release_i = rel;
    #1;
    chk("wr_slot",    bus.wr_slot_o,    m_wr);
    chk("rd_slot",    bus.rd_slot_o,    m_rd);
    chk("wr_frag",    bus.wr_frag_o,    m_frag);
    chk("flit_ready", bus.flit_ready_o, (m_occ != 0));
    chk("full",       bus.full_o,       (m_occ == NB));
    chk("flit_done",  bus.flit_done_o,  m_done);
    chk("frame_err",  bus.frame_err_o,  m_ferr);
    chk("overflow",   bus.overflow_o,   m_ovf);
    chk("underflow",  bus.underflow_o,  m_udf);
    chk("err_cnt",    bus.err_cnt_o,    m_err);
    exp_samp = 0; exp_beat = 0; commit = 0;
    if (rst) begin
      model_reset();
    end else begin
      m_done = 0; m_ferr = 0;
      if (!en) begin
        m_beat = 0; m_frag = 0; m_dropn = 0; m_drop = 0;
      end else if (m_beat == 0) begin
        if (v) begin
          if (m_dropn != 0) m_drop = 1;
          else if (m_frag != 0 || m_occ < NB) begin m_drop = 0; exp_samp = 1; end
          else begin m_drop = 1; m_ovf = 1; end
          m_beat = 1;
        end
      end else if (int'(v) == pat[m_beat]) begin
        exp_samp = !m_drop;
        exp_beat = m_beat;
        if (m_beat == 3) begin
          m_beat = 0;
          if (m_drop) m_dropn = (m_dropn + 1) % NF;
          else begin
            m_frag++;
            if (m_frag == NF) begin m_frag = 0; commit = 1; end
          end
          m_drop = 0;
        end else begin
          m_beat++;
        end
      end else begin
        m_ferr = 1;
        if (m_err < ERR_SAT) m_err++;
        m_beat = 0; m_frag = 0; m_dropn = 0; m_drop = 0;
      end
      rel_ok = rel && (m_occ > 0);
      if (rel && m_occ == 0) m_udf = 1;
      if (rel_ok) m_rd = (m_rd + 1) % NB;
      if (commit) begin m_wr = (m_wr + 1) % NB; m_done = 1; end
      m_occ = m_occ + int'(commit) - int'(rel_ok);
      chk("sample_en", bus.sample_en_o, exp_samp);
      if (exp_samp) chk("wr_beat", bus.wr_beat_o, exp_beat);
    end
    if (bus.sample_en_o === 1'b1) samples_seen++;
    @(posedge periph_clkPins_i);
    @(negedge periph_clkPins_i);
  endtask

  task automatic send_frag(input bit rel_last);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, rel_last);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.rx_enable_i = 1'b0; bus.valid_iPin = 1'b0; bus.buf_release_i = 1'b0;
    repeat (2) @(posedge periph_clkPins_i);
    @(negedge periph_clkPins_i);
    model_reset();
    idle(2);

    // Two clean flits fill both slots.
    samples_seen = 0;
    for (int f = 0; f < 8; f++) send_frag(0);
    idle(1);
    chk("samples_8frag", samples_seen, 32);
    chk("full_2flits", bus.full_o, 1'b1);
    chk("wr_slot_wrap", bus.wr_slot_o, 0);

    // Third flit while full is dropped entirely.
    samples_seen = 0;
    for (int f = 0; f < 4; f++) send_frag(0);
    idle(1);
    chk("no_sample_drop", samples_seen, 0);
    chk("overflow_set", bus.overflow_o, 1'b1);

    // One release frees slot 0; fourth flit lands there.
    step(0, 1, 0, 1);
    chk("wr_slot_before_4th", bus.wr_slot_o, 0);
    for (int f = 0; f < 4; f++) send_frag(0);
    idle(1);
    chk("full_after_4th", bus.full_o, 1'b1);

    // Framing error at fragment 2.
    step(0, 1, 0, 1);
    send_frag(0); send_frag(0);
    step(0, 1, 1, 0); step(0, 1, 0, 0);
    idle(1);
    chk("err_cnt_one", bus.err_cnt_o, 1);
    chk("frag_cleared", bus.wr_frag_o, 0);

    // Saturation of the error counter.
    for (int k = 0; k < 300; k++) begin step(0, 1, 1, 0); step(0, 1, 0, 0); end
    idle(1);
    chk("err_cnt_sat", bus.err_cnt_o, ERR_SAT);

    // Drain, then release at empty.
    step(0, 1, 0, 1); step(0, 1, 0, 1);
    idle(1);
    chk("underflow_set", bus.underflow_o, 1'b1);
    chk("ready_empty", bus.flit_ready_o, 1'b0);

    // Commit coinciding with a release at occupancy 1.
    for (int f = 0; f < 4; f++) send_frag(0);
    for (int f = 0; f < 3; f++) send_frag(0);
    send_frag(1);
    idle(1);
    chk("occ_kept_ready", bus.flit_ready_o, 1'b1);
    chk("occ_kept_notfull", bus.full_o, 1'b0);

    // Link drop at beat 2 of fragment 1, then a full flit.
    send_frag(0);
    step(0, 1, 1, 0); step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    idle(1);
    chk("abort_no_err", bus.frame_err_o, 1'b0);
    for (int f = 0; f < 4; f++) send_frag(0);
    idle(1);

    // Reset in the middle of a flit.
    step(0, 1, 0, 1);
    step(0, 1, 1, 0); step(0, 1, 1, 0);
    step(1, 1, 0, 0);
    chk("rst_err_cnt", bus.err_cnt_o, 0);
    chk("rst_overflow", bus.overflow_o, 1'b0);
    chk("rst_ready", bus.flit_ready_o, 1'b0);
    idle(1);

    // Randomized traffic: mostly well-formed fragments with gaps, glitches, releases, link drops.
    ph = 0;
    for (int i = 0; i < 2000; i++) begin
      bit en, v, rel;
      en  = ($urandom_range(0, 63) != 0);
      rel = ($urandom_range(0, 5) == 0);
      if (ph == 0 && $urandom_range(0, 7) == 0) begin
        v = 1'b0;
      end else begin
        v  = (ph < 2);
        ph = (ph + 1) % 4;
      end
      if ($urandom_range(0, 39) == 0) v = ~v;
      step(0, en, v, rel);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mb_rx_frame_ctrl.md
Name: mb_rx_frame_ctrl

Overview:
- Sequencing controller for the 16-lane MainBand receive flit buffer.
- Tracks the valid framing pattern: each 16B fragment is 4 beats with valid = 1,1,0,0; 4 fragments form one 64B flit.
- Generates per-beat write strobes and buffer/fragment/beat indices for the datapath.
- Manages flit-buffer occupancy against read-side releases; detects framing errors and overflow.

Parameters:
FLIT_BUFFERS, 2, number of flit slots; power of 2, >=2
FRAGS_PER_FLIT, 4, fragments per flit
ERR_CNT_W, 8, width of saturating framing-error counter

Ports:
periph_clkPins_i  in  1  receive forwarded clock; one beat sampled per rising edge
reset  in  1  synchronous, active-high
rx_enable_i  in  1  link trained; 0 = ignore lanes and abort any partial flit
valid_iPin  in  1  lane valid signal
buf_release_i  in  1  one-cycle pulse: read side consumed the oldest slot (already synchronized)
sample_en_o  out  1  datapath captures dataPins this cycle (combinational)
wr_slot_o  out  $clog2(FLIT_BUFFERS)  slot being written
wr_frag_o  out  2  fragment index within flit
wr_beat_o  out  2  beat 0..3 within fragment
rd_slot_o  out  $clog2(FLIT_BUFFERS)  oldest committed slot
flit_ready_o  out  1  occupancy != 0
flit_done_o  out  1  one-cycle pulse when a flit commits
full_o  out  1  occupancy == FLIT_BUFFERS
overflow_o  out  1  sticky; flit dropped because no slot was free
frame_err_o  out  1  one-cycle pulse on framing violation
err_cnt_o  out  ERR_CNT_W  saturating framing-error count
underflow_o  out  1  sticky; release received at occupancy 0

Behaviour:
Interface:
- Clock periph_clkPins_i; reset is synchronous, active-high.
- All registered outputs are 0 at reset; state = IDLE; pointers, fragment index, occupancy and counters are 0.

States:
- IDLE (beat 0): on rx_enable_i & valid_iPin:
  - If wr_frag_o != 0 or a slot is free: assert sample_en_o with wr_beat_o = 0, go to HI.
  - Else (frag 0, full): set overflow_o, go to DROP_HI; sample_en_o stays 0.
- HI (beat 1):
  - valid = 1: sample_en_o, beat 1, go to LO0.
  - valid = 0: framing error.
- LO0 (beat 2):
  - valid = 0: sample_en_o, beat 2, go to LO1.
  - valid = 1: framing error.
- LO1 (beat 3):
  - valid = 0: sample_en_o, beat 3, go to IDLE and increment wr_frag_o.
    - If wr_frag_o == FRAGS_PER_FLIT-1: wr_frag_o wraps to 0, wr_slot_o increments (wraps), occupancy increments, flit_done_o pulses next cycle.
  - valid = 1: framing error.
- DROP_HI / DROP_LO0 / DROP_LO1: same pattern checks, no sample_en_o. After LO1 of the dropped fragment, return to IDLE. All 4 fragments of the flit are dropped (drop fragment counter); the pattern resumes at the next flit boundary.

Framing error:
- frame_err_o pulses; err_cnt_o increments, saturating at all-ones.
- Return to IDLE; wr_frag_o reset to 0 (partial flit discarded, slot not committed).

Timing and boundaries:
- Back-to-back fragments (1100 1100 ...) sustain with no bubble, because IDLE consumes beat 0.
- sample_en_o, wr_beat_o: Mealy outputs, same cycle as the sampled beat. Other outputs are registered.
- buf_release_i: rd_slot_o increments (wraps), occupancy decrements.
  - Release at occupancy 0: ignored, underflow_o set.
  - Commit and release in the same cycle: occupancy unchanged, both pointers advance.
- Commit while occupancy will be full cannot happen: the admission check is done at beat 0 of fragment 0.
- rx_enable_i low mid-flit: go to IDLE next cycle, drop the partial flit, no error counted. Committed flits are retained.
- Reset mid-flit: all state cleared; committed data is abandoned.

Decomposition:
- Package mb_rx_pkg:
  - frame state enum {IDLE, HI, LO0, LO1, DROP_HI, DROP_LO0, DROP_LO1}
  - constants BEATS_PER_FRAG = 4, VALID_PATTERN = 4'b0011 (beat-indexed)
  - flit-size constants
- Sub-module: mb_rx_slot_tracker, holding the write/read pointers, occupancy, full/ready, and underflow logic. The FSM stays in the top.

Test Plan:
- 8 fragments of clean 1100 pattern, no release:
  - 32 sample_en_o, wr_beat_o cycling 0..3.
  - flit_done_o pulses twice; wr_slot_o goes 0→1→0.
  - full_o = 1; flit_ready_o = 1.
- While full, a third flit is sent:
  - overflow_o = 1, no sample_en_o, occupancy stays 2.
  - After one release, a fourth flit is accepted into slot 0.
- Valid pattern 1,0 at beats 0-1 of fragment 2:
  - frame_err_o pulses once; err_cnt_o = 1; wr_frag_o = 0; no flit_done_o.
- 300 consecutive framing errors: err_cnt_o saturates at 255.
- Release at occupancy 0: underflow_o = 1, occupancy stays 0. Commit and release in the same cycle at occupancy 1: occupancy stays 1, rd_slot_o and wr_slot_o both advance.
- rx_enable_i drops at beat 2 of fragment 1, then a full flit is sent:
  - No error; the partial flit is discarded.
  - The new flit commits to the same wr_slot_o. Reset asserted mid-flit clears all outputs to 0 next edge.
